// File: rtl/ahb_lite_fir_slave_p.sv
// ahb_lite_fir_slave_p: AHB-Lite register slave feeding a sample FIFO and coefficients to a FIR filter
module ahb_lite_fir_slave_p #(
  parameter int NUM_COEFF = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         hsel,
  input  logic [ADDR_W-1:0]            haddr,
  input  logic                         hsize,
  input  logic [1:0]                   htrans,
  input  logic                         hwrite,
  input  logic [15:0]                  hwdata,
  output logic [15:0]                  hrdata,
  output logic                         hresp,
  output logic                         hready,
  input  logic [$clog2(NUM_COEFF)-1:0] coefficient_num,
  input  logic                         modwait,
  input  logic [15:0]                  fir_out,
  input  logic                         err,
  input  logic                         sample_ack,
  output logic [15:0]                  sample_data,
  output logic                         data_ready,
  output logic                         new_coefficient_set,
  output logic [15:0]                  fir_coefficient
);
  localparam int CW = $clog2(NUM_COEFF);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int C_IX = 3 + NUM_COEFF;
  typedef enum logic {ST_RUN, ST_ERR2} state_t;
  state_t state, state_nxt;
  logic d_valid, d_size, d_write;
  logic [ADDR_W-1:0] d_addr;
  logic [31:0] ix;
  logic bad, ok, wr, rd, push, pop, do_push, full, empty, ncs, overrun, err_r;
  logic [1:0] be;
  logic [15:0] result, last_sample, rd_reg, status, push_data;
  logic [7:0] staging;
  logic [15:0] coeff [NUM_COEFF];
  logic [15:0] coeff_ext [2**CW];
  logic [15:0] fifo [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] count;
  logic unused_htrans;
  function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] d, input logic [1:0] m);
    return {m[1] ? d[15:8] : old[15:8], m[0] ? d[7:0] : old[7:0]};
  endfunction
  assign unused_htrans = htrans[0];
  assign ix = 32'(d_addr[ADDR_W-1:1]);
  // C is a byte-only register; its odd byte and everything above it are unmapped
  assign bad = ix > C_IX || (ix == C_IX && (d_addr[0] || d_size)) || (d_write && ix == 1) || (d_size && d_addr[0]);
  assign ok = d_valid && !bad && state == ST_RUN;
  assign wr = ok && d_write;
  assign rd = ok && !d_write;
  assign be = d_size ? 2'b11 : {d_addr[0], !d_addr[0]};
  assign empty = count == '0;
  assign full = count == (AW+1)'(FIFO_DEPTH);
  assign push = wr && ix == 2 && (d_size || d_addr[0]);
  assign pop = sample_ack && !empty;
  assign do_push = push && (!full || pop);
  assign push_data = d_size ? hwdata : {hwdata[15:8], staging};
  assign status = {6'b0, overrun, err_r, 5'b0, empty, full, modwait | ncs};
  assign sample_data = empty ? '0 : fifo[rp];
  assign data_ready = !empty;
  assign new_coefficient_set = ncs;
  for (genvar g = 0; g < 2**CW; g++) begin : g_ce
    if (g < NUM_COEFF) begin : g_c
      assign coeff_ext[g] = coeff[g];
    end else begin : g_z
      assign coeff_ext[g] = '0;
    end
  end
  assign fir_coefficient = coeff_ext[coefficient_num];
  always_comb begin
    rd_reg = ix == 0 ? status : ix == 1 ? result : ix == 2 ? last_sample : ix == C_IX ? {15'b0, ncs} : '0;
    for (int k = 0; k < NUM_COEFF; k++) if (ix == 3 + k) rd_reg = coeff[k];
    hrdata = !rd ? '0 : d_size ? rd_reg : d_addr[0] ? {rd_reg[15:8], 8'h00} : {8'h00, rd_reg[7:0]};
  end
  always_comb begin
    state_nxt = ST_RUN;
    hresp = 1'b0;
    hready = 1'b1;
    if (state == ST_ERR2) hresp = 1'b1;
    else if (d_valid && bad) begin
      hresp = 1'b1;
      hready = 1'b0;
      state_nxt = ST_ERR2;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_RUN;
      d_valid <= 1'b0;
      d_size <= 1'b0;
      d_write <= 1'b0;
      d_addr <= '0;
      result <= '0;
      last_sample <= '0;
      staging <= '0;
      ncs <= 1'b0;
      overrun <= 1'b0;
      err_r <= 1'b0;
      wp <= '0;
      rp <= '0;
      count <= '0;
      for (int k = 0; k < NUM_COEFF; k++) coeff[k] <= '0;
      for (int k = 0; k < FIFO_DEPTH; k++) fifo[k] <= '0;
    end else begin
      state <= state_nxt;
      if (hready) begin
        d_valid <= hsel && htrans[1];
        d_addr <= haddr;
        d_size <= hsize;
        d_write <= hwrite;
      end
      err_r <= err;
      if (!modwait) result <= fir_out;
      if (wr && ix == 2 && !d_size && !d_addr[0]) staging <= hwdata[7:0];
      if (push) last_sample <= push_data;
      if (do_push) begin
        fifo[wp] <= push_data;
        wp <= wp + 1'b1;
      end
      if (pop) rp <= rp + 1'b1;
      count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, pop};
      if (push && full && !pop) overrun <= 1'b1;
      else if (wr && ix == 0 && be[1] && hwdata[9]) overrun <= 1'b0;
      // a master write to C takes priority over the FIR's end-of-load clear
      if (wr && ix == C_IX) ncs <= hwdata[0];
      else if (coefficient_num == CW'(NUM_COEFF - 1) && !modwait) ncs <= 1'b0;
      for (int k = 0; k < NUM_COEFF; k++) if (wr && ix == 3 + k) coeff[k] <= merge(coeff[k], hwdata, be);
    end
  end
endmodule

// File: doc/ahb_lite_fir_slave_p.md
AHB_LITE_FIR_SLAVE_P -- requirements
Module: ahb_lite_fir_slave_p

Interface
REQ-001 SHALL have parameter NUM_COEFF, default 4, meaning FIR coefficient count (legal 2..8).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning sample FIFO entries (power of 2, 2..16).
REQ-003 SHALL have parameter ADDR_W, default 5, meaning haddr width (2^ADDR_W >= 8+2*NUM_COEFF).
REQ-004 Clocking SHALL be one clock, clk; reset SHALL be rst, synchronous and active-high.
REQ-005 Ports SHALL be as follows, in this order:
 - clk  in  1  clock
 - rst  in  1  synchronous active-high reset
 - hsel  in  1  slave select
 - haddr  in  ADDR_W  byte address
 - hsize  in  1  0=byte, 1=halfword
 - htrans  in  2  AHB transfer type; transfer valid when htrans[1]=1
 - hwrite  in  1  1=write
 - hwdata  in  16  write data, byte lanes per address bit 0
 - hrdata  out  16  read data
 - hresp  out  1  1=ERROR
 - hready  out  1  0=stall
 - coefficient_num  in  clog2(NUM_COEFF)  coefficient index requested by FIR
 - modwait  in  1  FIR busy
 - fir_out  in  16  FIR result
 - err  in  1  FIR error
 - sample_ack  in  1  FIR consumed head sample (pulse)
 - sample_data  out  16  FIFO head
 - data_ready  out  1  FIFO non-empty
 - new_coefficient_set  out  1  coefficient reload request
 - fir_coefficient  out  16  coefficient[coefficient_num]

Function
REQ-006 Address map (halfword registers at even byte addresses) SHALL be:
 - 0x00 status
 - 0x02 result (RO)
 - 0x04 sample (W=push, R=last pushed value)
 - 0x06+2k coefficient k, k<NUM_COEFF
 - C=0x06+2*NUM_COEFF new_coefficient_set, bit0 only
 - all other addresses unmapped
REQ-007 Status fields SHALL be:
 - [0] modwait|new_coefficient_set
 - [1] FIFO full
 - [2] FIFO empty
 - [8] err, registered
 - [9] overrun, sticky
 - all other bits 0
REQ-008 A write to status with hwdata[9]=1 SHALL clear overrun (write-1-to-clear); all other status bits SHALL ignore writes.
REQ-009 The address phase SHALL be captured (addr, size, write, valid) when hsel=1, htrans[1]=1 and hready=1; the data phase SHALL occur in the following cycle.
REQ-010 An address phase SHALL be an error if any of the following holds:
 - unmapped address
 - write to 0x02/0x03
 - halfword access at an odd address
 - halfword access to C
REQ-011 An error SHALL produce a two-cycle response: cycle 1 hresp=1, hready=0; cycle 2 hresp=1, hready=1; no register changes.
REQ-012 A non-error data phase SHALL drive hready=1, hresp=0; idle SHALL also drive hready=1, hresp=0.
REQ-013 Read data SHALL be driven in the data phase:
 - halfword: full register
 - byte, even address: byte on [7:0], [15:8]=0
 - byte, odd address: byte on [15:8], [7:0]=0
 - hrdata SHALL be 0 when there is no read data phase.
REQ-014 Byte writes SHALL take data from the addressed lane (even: hwdata[7:0], odd: hwdata[15:8]) and leave the other byte unchanged.
REQ-015 A read data phase immediately following a write data phase to the same register SHALL return the newly written value.
REQ-016 Sample pushes SHALL follow these rules:
 - halfword write to 0x04 pushes hwdata.
 - byte write to 0x04 updates the staging low byte only.
 - byte write to 0x05 pushes {hwdata[15:8], staging low byte}.
REQ-017 A push to a full FIFO SHALL be dropped and SHALL set overrun, unless sample_ack pops in the same cycle, in which case both occur.
REQ-018 sample_ack SHALL pop only when data_ready=1; sample_ack while empty SHALL be ignored, and a push to an empty FIFO SHALL still succeed in that cycle.
REQ-019 data_ready SHALL be 1 whenever the FIFO count > 0; sample_data SHALL be the FIFO head (0 when empty).
REQ-020 The result register SHALL load fir_out every cycle in which modwait=0.
REQ-021 fir_coefficient SHALL equal coefficient[coefficient_num] combinationally; an index >= NUM_COEFF SHALL return 0.
REQ-022 new_coefficient_set SHALL be set by a master write of 1 to C.
 - It SHALL be cleared by hardware when coefficient_num==NUM_COEFF-1 and modwait=0.
 - If a master write and the hardware clear occur in the same cycle, the master write SHALL win.
REQ-023 FIFO pointers SHALL wrap modulo FIFO_DEPTH; the count SHALL range 0..FIFO_DEPTH.

Reset
REQ-024 While rst=1 at a clk edge, all registers, the FIFO, staging byte, overrun, and the pending address phase SHALL clear to 0.
REQ-025 After reset: hready=1, hresp=0, hrdata=0, data_ready=0, new_coefficient_set=0, sample_data=0, fir_coefficient=0.
REQ-026 Reset asserted mid-transfer or mid-error SHALL abort it, with no register update.

Verification
REQ-027 Halfword write 0x1234 to 0x06, then halfword read 0x06 -> hrdata=0x1234; byte read 0x07 -> hrdata=0x1200.
REQ-028 FIFO_DEPTH=4: five halfword pushes of 1..5 with no ack -> status[1]=1, status[9]=1, sample_data=1; four acks -> 1,2,3,4 in order, then data_ready=0.
REQ-029 Halfword write to 0x02 -> cycle 1 hresp=1/hready=0, cycle 2 hresp=1/hready=1; result unchanged.
REQ-030 Write 1 to C; drive coefficient_num=NUM_COEFF-1 with modwait=0 -> new_coefficient_set=0 next cycle; status[0] follows.
REQ-031 Byte write 0xAB to 0x04, then byte write 0xCD00 to 0x05 -> one push, sample_data=0xCDAB.
REQ-032 Assert rst during the first error cycle -> next cycle hready=1, hresp=0, all registers 0.
